// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - XLEN_DEFAULT : default operand/result width
//   - OP_*         : funct3 encodings of the RV32M operations
//   - state_t      : control FSM state encoding
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational conditional two's-complement negate. Used both to turn signed
// operands into magnitudes and to apply the final sign to product, quotient
// and remainder.
// Ports:
//   val_in  [W-1:0]  value to correct
//   neg              1 = negate, 0 = pass through
//   val_out [W-1:0]  corrected value
// -----------------------------------------------------------------------------
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_in,
    input  logic         neg,
    output logic [W-1:0] val_out
);

    assign val_out = neg ? (~val_in + W'(1)) : val_in;

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative RV32M multiply/divide unit, one operation in flight. Multiplies by
// shift-add and divides by restoring division, one bit per cycle, on a shared
// 2*XLEN accumulator. The completed result is handed to the register file
// write port as (wb_addr, result, wb_we).
//
// Optional build macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and a
// zero multiply operand skip the iterations (done two cycles after start).
// Results are the same with or without it.
//
// Ports:
//   clk      clock, rising edge
//   res      synchronous active-high reset (aborts any operation in flight)
//   start    operation request, accepted in IDLE or DONE
//   funct3   RV32M operation select
//   rs1_val  operand A, rs2_val operand B (sampled only at acceptance)
//   rd_addr  destination register
//   busy     operation in progress
//   done     one-cycle completion pulse
//   result   result, held until the next completion
//   wb_addr  destination register of the completed op
//   wb_we    register file write enable (done and wb_addr != 0)
// -----------------------------------------------------------------------------
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    rs1_val,
    input  logic [XLEN-1:0]    rs2_val,
    input  logic [RADDR_W-1:0] rd_addr,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result,
    output logic [RADDR_W-1:0] wb_addr,
    output logic               wb_we
);

    localparam int CNT_W = $clog2(XLEN + 1);

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [RADDR_W-1:0]    rd_q, rd_d;
    logic [RADDR_W-1:0]    wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]       b_q, b_d;
    logic [XLEN-1:0]       a_orig_q, a_orig_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;          // product / quotient sign
    logic                  rem_neg_q, rem_neg_d;  // remainder sign
    logic                  div_zero_q, div_zero_d;
    logic                  ovf_q, ovf_d;
`ifdef MDU_EARLY_OUT_EN
    logic                  mul_zero_q, mul_zero_d;
`endif

    // ---------------- operand decode at acceptance ----------------
    logic            a_signed, b_signed, s_a, s_b;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                      (funct3 == OP_DIV)  || (funct3 == OP_REM);
    assign b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    assign s_a      = a_signed && rs1_val[XLEN-1];
    assign s_b      = b_signed && rs2_val[XLEN-1];

    mdu_sign_fix #(.W(XLEN)) u_fix_a (.val_in(rs1_val), .neg(s_a), .val_out(a_mag));
    mdu_sign_fix #(.W(XLEN)) u_fix_b (.val_in(rs2_val), .neg(s_b), .val_out(b_mag));

    // ---------------- iteration datapath ----------------
    // Multiply: accumulator starts as {0, A}; each step adds B to the upper
    // half when the LSB is set, then shifts the whole thing right by one.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: accumulator starts as {0, A}; upper half is the
    // partial remainder, lower half shifts the dividend out and quotient in.
    logic [XLEN:0]     div_r;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;

    assign div_r    = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = (div_r >= {1'b0, b_q});
    // When div_ge holds the difference is below B, so the low XLEN bits suffice.
    assign div_diff = div_r[XLEN-1:0] - b_q;
    assign div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                             : {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    // ---------------- result correction ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   mul_res, div_res, final_res;

    mdu_sign_fix #(.W(2*XLEN)) u_fix_prod (.val_in(acc_q), .neg(neg_q), .val_out(prod_fix));
    mdu_sign_fix #(.W(XLEN)) u_fix_quot (.val_in(acc_q[XLEN-1:0]), .neg(neg_q), .val_out(quot_fix));
    mdu_sign_fix #(.W(XLEN)) u_fix_rem (.val_in(acc_q[2*XLEN-1:XLEN]), .neg(rem_neg_q), .val_out(rem_fix));

    always_comb begin
        mul_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MDU_EARLY_OUT_EN
        // Early-out skips the iterations, so the accumulator is not a product.
        if (mul_zero_q) begin
            mul_res = '0;
        end
`endif
        // op_q[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero_q) begin
            div_res = op_q[1] ? a_orig_q : '1;
        end else if (ovf_q) begin
            div_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            div_res = op_q[1] ? rem_fix : quot_fix;
        end
        final_res = (state_q == S_MUL) ? mul_res : div_res;
    end

    // ---------------- completion condition ----------------
    logic finish;
`ifdef MDU_EARLY_OUT_EN
    assign finish = (cnt_q == CNT_W'(XLEN)) ||
                    ((div_zero_q || ovf_q || mul_zero_q) && (cnt_q == CNT_W'(1)));
`else
    assign finish = (cnt_q == CNT_W'(XLEN));
`endif

    // ---------------- FSM next state / datapath ----------------
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        wb_addr_d  = wb_addr_q;
        b_d        = b_q;
        a_orig_d   = a_orig_q;
        result_d   = result_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
`ifdef MDU_EARLY_OUT_EN
        mul_zero_d = mul_zero_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d    = funct3[2] ? S_DIV : S_MUL;
                    op_d       = funct3;
                    rd_d       = rd_addr;
                    b_d        = b_mag;
                    a_orig_d   = rs1_val;
                    acc_d      = {{XLEN{1'b0}}, a_mag};
                    cnt_d      = '0;
                    neg_d      = s_a ^ s_b;
                    rem_neg_d  = s_a;
                    div_zero_d = funct3[2] && (rs2_val == '0);
                    // Signed DIV/REM have funct3[0] = 0.
                    ovf_d      = funct3[2] && !funct3[0] &&
                                 (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                                 (rs2_val == '1);
`ifdef MDU_EARLY_OUT_EN
                    mul_zero_d = !funct3[2] && ((rs1_val == '0) || (rs2_val == '0));
`endif
                end
            end
            S_MUL, S_DIV: begin
                if (finish) begin
                    state_d   = S_DONE;
                    result_d  = final_res;
                    wb_addr_d = rd_q;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            wb_addr_q  <= '0;
            b_q        <= '0;
            a_orig_q   <= '0;
            result_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
            mul_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            wb_addr_q  <= wb_addr_d;
            b_q        <= b_d;
            a_orig_q   <= a_orig_d;
            result_q   <= result_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
`ifdef MDU_EARLY_OUT_EN
            mul_zero_q <= mul_zero_d;
`endif
        end
    end

    assign busy    = (state_q == S_MUL) || (state_q == S_DIV);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign wb_addr = wb_addr_q;
    assign wb_we   = done && (wb_addr_q != '0);

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed self-checking bench for mul_div_unit. Each scenario task drives its
// own stimulus and compares against hand-computed values. Honours
// MDU_EARLY_OUT_EN for the expected latency of the special cases.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
    import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, wb_we;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    int pass_cnt = 0;
    int total_cnt = 0;

    mul_div_unit #(.XLEN(32), .RADDR_W(5)) dut (
        .clk     (clk),
        .res     (res),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wb_addr (wb_addr),
        .wb_we   (wb_we)
    );

    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for done. lat = cycles from the accepting
    // edge to the edge that raises done, -1 on timeout. Operands are scrambled
    // right after acceptance to show they are not re-sampled.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] r, output int lat,
                          output logic we, output logic [4:0] wa, output logic bz);
        r = '0; lat = -1; we = 1'b0; wa = '0; bz = 1'b1;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i; r = result; we = wb_we; wa = wb_addr; bz = busy;
                break;
            end
        end
        $display("op f=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d wb_we=%b wb_addr=%0d",
                 f, a, b, rd, r, lat, we, wa);
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        total_cnt++;
        if ({busy, done, wb_we} !== 3'b000 || result !== 32'h0 || wb_addr !== 5'd0)
            $display("FAIL reset_state: busy/done/we=%b%b%b result=%h wb_addr=%0d expected 000 0 0",
                     busy, done, wb_we, result, wb_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; int lat; logic we; logic [4:0] wa; logic bz;
        int done_seen;
        @(negedge clk);
        start = 1'b1; funct3 = OP_MUL; rs1_val = 32'd7; rs2_val = 32'd6; rd_addr = 5'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) res = 1'b1;
        @(posedge clk);
        #1 res = 1'b0;
        total_cnt++;
        if ({busy, done, wb_we} !== 3'b000)
            $display("FAIL mid_op_reset: busy/done/we=%b%b%b expected 000", busy, done, wb_we);
        else pass_cnt++;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || wb_we) done_seen++;
        end
        total_cnt++;
        if (done_seen !== 0)
            $display("FAIL aborted_no_done: done cycles=%0d expected 0", done_seen);
        else pass_cnt++;
        run_op(OP_MUL, 32'd7, 32'd6, 5'd4, r, lat, we, wa, bz);
        total_cnt++;
        if (r !== 32'd42 || lat !== FULL_LAT)
            $display("FAIL mul_after_reset: result=%h lat=%0d expected 0000002a lat=%0d", r, lat, FULL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        logic [2:0]  f  [6] = '{OP_MULH, OP_MUL, OP_MULHU, OP_MULHSU, OP_MUL, OP_MULH};
        logic [31:0] a  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        logic [31:0] b  [6] = '{32'h3, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h80000000};
        logic [31:0] ex [6] = '{32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h40000000};
        int          el [6] = '{FULL_LAT, FULL_LAT, FULL_LAT, FULL_LAT, SPEC_LAT, FULL_LAT};
        logic [31:0] r; int lat; logic we; logic [4:0] wa; logic bz;
        for (int i = 0; i < 6; i++) begin
            run_op(f[i], a[i], b[i], 5'd1, r, lat, we, wa, bz);
            total_cnt++;
            if (r !== ex[i] || lat !== el[i] || bz !== 1'b0)
                $display("FAIL mul_%0d: result=%h lat=%0d busy=%b expected %h lat=%0d busy=0",
                         i, r, lat, bz, ex[i], el[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  f  [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] a  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] b  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] ex [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        logic [31:0] r; int lat; logic we; logic [4:0] wa; logic bz;
        for (int i = 0; i < 6; i++) begin
            run_op(f[i], a[i], b[i], 5'd2, r, lat, we, wa, bz);
            total_cnt++;
            if (r !== ex[i] || lat !== FULL_LAT)
                $display("FAIL div_%0d: result=%h lat=%0d expected %h lat=%0d", i, r, lat, ex[i], FULL_LAT);
            else pass_cnt++;
        end
    endtask

    task automatic test_special();
        logic [2:0]  f  [7] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] a  [7] = '{32'd42, 32'd42, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] b  [7] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] ex [7] = '{32'hFFFFFFFF, 32'd42, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd0};
        int          el [7] = '{SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, FULL_LAT};
        logic [31:0] r; int lat; logic we; logic [4:0] wa; logic bz;
        for (int i = 0; i < 7; i++) begin
            run_op(f[i], a[i], b[i], 5'd3, r, lat, we, wa, bz);
            total_cnt++;
            if (r !== ex[i] || lat !== el[i])
                $display("FAIL special_%0d: result=%h lat=%0d expected %h lat=%0d", i, r, lat, ex[i], el[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore();
        int          dones, first;
        logic [31:0] r;
        logic        bz5;
        dones = 0; first = -1; r = '0; bz5 = 1'b0;
        @(negedge clk);
        start = 1'b1; funct3 = OP_MULHU; rs1_val = 32'hFFFFFFFF; rs2_val = 32'hFFFFFFFF; rd_addr = 5'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                start = 1'b1; funct3 = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd3;
            end
            if (i == 5) begin
                start = 1'b0; bz5 = busy;
            end
            if (done) begin
                dones++;
                if (first < 0) begin first = i; r = result; end
            end
        end
        $display("op busy-ignore: dones=%0d first=%0d result=%h", dones, first, r);
        total_cnt++;
        if (dones !== 1 || first !== FULL_LAT || r !== 32'hFFFFFFFE || bz5 !== 1'b1)
            $display("FAIL start_while_busy: dones=%0d at=%0d result=%h busy=%b expected 1 at %0d fffffffe busy=1",
                     dones, first, r, bz5, FULL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, r2; int lat, gap; logic we; logic [4:0] wa; logic bz;
        run_op(OP_MUL, 32'd7, 32'd6, 5'd5, r, lat, we, wa, bz);
        // Still inside the DONE cycle: issue the second op here.
        @(negedge clk);
        start = 1'b1; funct3 = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd6;
        gap = -1; r2 = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
            if (done) begin gap = i; r2 = result; break; end
        end
        $display("op back-to-back: first=%h second=%h gap=%0d", r, r2, gap);
        total_cnt++;
        if (r !== 32'd42 || r2 !== 32'd14 || gap !== 34)
            $display("FAIL back_to_back: first=%h second=%h gap=%0d expected 2a 0e gap=34", r, r2, gap);
        else pass_cnt++;
    endtask

    task automatic test_writeback();
        logic [31:0] r; int lat; logic we; logic [4:0] wa; logic bz;
        run_op(OP_MUL, 32'd7, 32'd6, 5'd0, r, lat, we, wa, bz);
        total_cnt++;
        if (lat !== FULL_LAT || we !== 1'b0 || r !== 32'd42)
            $display("FAIL wb_rd0: lat=%0d wb_we=%b result=%h expected lat=%0d we=0 2a", lat, we, r, FULL_LAT);
        else pass_cnt++;
        run_op(OP_DIVU, 32'd100, 32'd10, 5'd10, r, lat, we, wa, bz);
        total_cnt++;
        if (we !== 1'b1 || wa !== 5'd10 || r !== 32'd10 || lat !== FULL_LAT)
            $display("FAIL wb_rd10: wb_we=%b wb_addr=%0d result=%h lat=%0d expected 1 10 0000000a %0d",
                     we, wa, r, lat, FULL_LAT);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0 || wb_we !== 1'b0 || result !== 32'd10 || wb_addr !== 5'd10)
            $display("FAIL wb_one_cycle: done=%b wb_we=%b result=%h wb_addr=%0d expected 0 0 0000000a 10",
                     done, wb_we, result, wb_addr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_mul();
        test_div();
        test_special();
        test_busy_ignore();
        test_back_to_back();
        test_writeback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
